control_sequencer: RTL and testbench

Multi-cycle control state machine for the TRISC CPU. It sits directly downstream of the 4-to-16 opcode decoder. It consumes the decoder's one-hot instruction lines and produces the per-cycle control strobes for the PC, MAR, IR, memory bus and accumulator/ALU. It runs fetch, decode and execute for the 11 defined instructions, handles the memory request/acknowledge handshake with a timeout, and parks in a halt state on HLT or on a bus error.

---
 rtl/control_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_control_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: multi-cycle fetch/decode/execute controller for the TRISC CPU.
// Consumes one-hot decode lines and drives per-cycle strobes for PC, MAR, IR,
// memory bus and accumulator/ALU, with a bounded memory handshake.
module control_sequencer #(
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [0:15] D,
    input  logic        z_flag,
    input  logic        n_flag,
    input  logic        mem_ack,
    output logic        mar_load,
    output logic        mar_src,
    output logic        mem_req,
    output logic        mem_we,
    output logic        ir_load,
    output logic        pc_inc,
    output logic        pc_load,
    output logic        acc_load,
    output logic [1:0]  alu_op,
    output logic        acc_inc,
    output logic        acc_clr,
    output logic        halted,
    output logic        illegal_op,
    output logic        bus_error,
    output logic [2:0]  state
);

    typedef enum logic [2:0] {
        StF0   = 3'd0,
        StF1   = 3'd1,
        StDec  = 3'd2,
        StMem  = 3'd3,
        StHalt = 3'd7
    } state_e;

    // Op codes follow the D bit index; OpIll marks an undecodable instruction.
    typedef enum logic [3:0] {
        OpLda = 4'd0,
        OpSta = 4'd1,
        OpAdd = 4'd2,
        OpSub = 4'd3,
        OpXor = 4'd4,
        OpInc = 4'd5,
        OpClr = 4'd6,
        OpJmp = 4'd7,
        OpJpn = 4'd8,
        OpJpz = 4'd9,
        OpHlt = 4'd10,
        OpIll = 4'd15
    } op_e;

    state_e     state_q, state_d;
    op_e        op_q, op_d;
    op_e        op_dec;
    logic [3:0] hot_cnt;
    logic [7:0] wait_q, wait_d;
    logic       timeout;

    // Decode the live one-hot lines; anything but exactly one defined bit is illegal.
    always_comb begin
        hot_cnt = 4'd0;
        op_dec  = OpIll;
        for (int i = 0; i < 11; i++) begin
            if (D[i]) begin
                hot_cnt = hot_cnt + 4'd1;
                op_dec  = op_e'(i[3:0]);
            end
        end
        if (hot_cnt != 4'd1 || D[11:15] != 5'b0) begin
            op_dec = OpIll;
        end
    end

    // An ack in the last allowed cycle still wins over the timeout.
    assign timeout = !mem_ack && (wait_q == 8'(WAIT_MAX));

    // State, latched op and wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StF0;
            op_q    <= OpLda;
            wait_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state and strobe decode.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        wait_d     = wait_q;
        mar_load   = 1'b0;
        mar_src    = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        ir_load    = 1'b0;
        pc_inc     = 1'b0;
        pc_load    = 1'b0;
        acc_load   = 1'b0;
        alu_op     = 2'b00;
        acc_inc    = 1'b0;
        acc_clr    = 1'b0;
        halted     = 1'b0;
        illegal_op = 1'b0;
        bus_error  = 1'b0;

        unique case (state_q)
            StF0: begin
                mar_load = 1'b1;
                wait_d   = 8'd0;
                state_d  = StF1;
            end
            StF1: begin
                mem_req = 1'b1;
                if (mem_ack) begin
                    ir_load = 1'b1;
                    pc_inc  = 1'b1;
                    state_d = StDec;
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                end
            end
            StDec: begin
                op_d    = op_dec;
                state_d = StF0;
                case (op_dec)
                    OpLda, OpSta, OpAdd, OpSub, OpXor: begin
                        mar_src  = 1'b1;
                        mar_load = 1'b1;
                        wait_d   = 8'd0;
                        state_d  = StMem;
                    end
                    OpInc:   acc_inc = 1'b1;
                    OpClr:   acc_clr = 1'b1;
                    OpJmp:   pc_load = 1'b1;
                    OpJpn:   pc_load = n_flag;
                    OpJpz:   pc_load = z_flag;
                    OpHlt:   state_d = StHalt;
                    default: illegal_op = 1'b1;
                endcase
            end
            StMem: begin
                mem_req = 1'b1;
                mem_we  = (op_q == OpSta);
                if (mem_ack) begin
                    state_d = StF0;
                    case (op_q)
                        OpLda: begin acc_load = 1'b1; alu_op = 2'b00; end
                        OpAdd: begin acc_load = 1'b1; alu_op = 2'b01; end
                        OpSub: begin acc_load = 1'b1; alu_op = 2'b10; end
                        OpXor: begin acc_load = 1'b1; alu_op = 2'b11; end
                        default: ;
                    endcase
                end else if (timeout) begin
                    bus_error = 1'b1;
                    state_d   = StHalt;
                end else begin
                    wait_d = (wait_q == 8'hFF) ? wait_q : wait_q + 8'd1;
                end
            end
            StHalt: begin
                halted = 1'b1;
            end
            default: begin
                state_d = StF0;
            end
        endcase

        // Strobes are silent while reset is held, including the F0 MAR load.
        if (!rst_n) begin
            mar_load   = 1'b0;
            mar_src    = 1'b0;
            mem_req    = 1'b0;
            mem_we     = 1'b0;
            ir_load    = 1'b0;
            pc_inc     = 1'b0;
            pc_load    = 1'b0;
            acc_load   = 1'b0;
            alu_op     = 2'b00;
            acc_inc    = 1'b0;
            acc_clr    = 1'b0;
            halted     = 1'b0;
            illegal_op = 1'b0;
            bus_error  = 1'b0;
        end
    end

    assign state = rst_n ? state_q : 3'd0;

endmodule

// File: tb/tb_control_sequencer.sv
// Scoreboard bench for control_sequencer: each driven cycle queues the expected
// output vector, a negedge monitor pops and compares it.
module tb_control_sequencer;

    localparam int unsigned WaitMax = 15;

    localparam logic [17:0] MMarl = 18'h20000;
    localparam logic [17:0] MMars = 18'h10000;
    localparam logic [17:0] MReq  = 18'h08000;
    localparam logic [17:0] MWe   = 18'h04000;
    localparam logic [17:0] MIrl  = 18'h02000;
    localparam logic [17:0] MPci  = 18'h01000;
    localparam logic [17:0] MPcl  = 18'h00800;
    localparam logic [17:0] MAccl = 18'h00400;
    localparam logic [17:0] MAcci = 18'h00080;
    localparam logic [17:0] MAccc = 18'h00040;
    localparam logic [17:0] MHalt = 18'h00020;
    localparam logic [17:0] MIll  = 18'h00010;
    localparam logic [17:0] MBerr = 18'h00008;
    localparam logic [17:0] St0   = 18'd0;
    localparam logic [17:0] St1   = 18'd1;
    localparam logic [17:0] St2   = 18'd2;
    localparam logic [17:0] St3   = 18'd3;
    localparam logic [17:0] St7   = 18'd7;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [0:15] D;
    logic        z_flag, n_flag, mem_ack;
    logic        mar_load, mar_src, mem_req, mem_we, ir_load, pc_inc, pc_load;
    logic        acc_load, acc_inc, acc_clr, halted, illegal_op, bus_error;
    logic [1:0]  alu_op;
    logic [2:0]  state;
    logic [17:0] obs;

    always #5 clk = ~clk;

    control_sequencer #(.WAIT_MAX(WaitMax)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .D          (D),
        .z_flag     (z_flag),
        .n_flag     (n_flag),
        .mem_ack    (mem_ack),
        .mar_load   (mar_load),
        .mar_src    (mar_src),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .ir_load    (ir_load),
        .pc_inc     (pc_inc),
        .pc_load    (pc_load),
        .acc_load   (acc_load),
        .alu_op     (alu_op),
        .acc_inc    (acc_inc),
        .acc_clr    (acc_clr),
        .halted     (halted),
        .illegal_op (illegal_op),
        .bus_error  (bus_error),
        .state      (state)
    );

    assign obs = {mar_load, mar_src, mem_req, mem_we, ir_load, pc_inc, pc_load, acc_load,
                  alu_op, acc_inc, acc_clr, halted, illegal_op, bus_error, state};

    int n_checks = 0;
    int n_fail   = 0;

    logic [17:0] exp_q[$];
    string       tag_q[$];

    task automatic check(input string tag, input logic [17:0] got, input logic [17:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %05h expected %05h", tag, got, exp);
        end
    endtask

    // Compare away from the rising edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [17:0] e;
            string       t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, obs, e);
        end
    end

    function automatic logic [0:15] oh(input int i);
        logic [0:15] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic step(input string tag, input logic r, input logic [0:15] d, input logic z,
                        input logic n, input logic ack, input logic [17:0] e);
        @(posedge clk);
        #1;
        rst_n   = r;
        D       = d;
        z_flag  = z;
        n_flag  = n;
        mem_ack = ack;
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 3; i++) step("reset", 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 18'd0);
    endtask

    task automatic halt_cycles(input int cnt);
        for (int i = 0; i < cnt; i++) begin
            step("halt", 1'b1, 16'h0, 1'b0, 1'b0, i[0], MHalt | St7);
        end
    endtask

    // Reference sequence for one instruction; delays > WaitMax force a timeout.
    task automatic do_instr(input string name, input logic [0:15] d, input logic z,
                            input logic n, input int f1_delay, input int mem_delay);
        int          cnt;
        int          op;
        bit          legal;
        logic [0:15] noise;
        logic [17:0] we;
        logic [17:0] e;
        logic [1:0]  alu;
        cnt = 0;
        op  = -1;
        for (int i = 0; i < 11; i++) begin
            if (d[i]) begin
                cnt++;
                op = i;
            end
        end
        legal = (cnt == 1) && (d[11:15] == 5'b0);
        noise = 16'hFFFF;
        // ack outside F1/MEM must be ignored
        step({name, " F0"}, 1'b1, d, z, n, 1'b1, MMarl | St0);
        for (int k = 0; k <= WaitMax; k++) begin
            if (k == f1_delay) begin
                step({name, " F1 ack"}, 1'b1, d, z, n, 1'b1, MReq | MIrl | MPci | St1);
                break;
            end else if (k == WaitMax) begin
                step({name, " F1 timeout"}, 1'b1, d, z, n, 1'b0, MReq | MBerr | St1);
                return;
            end else begin
                step({name, " F1 wait"}, 1'b1, d, z, n, 1'b0, MReq | St1);
            end
        end
        if (!legal) begin
            step({name, " DEC illegal"}, 1'b1, d, z, n, 1'b1, MIll | St2);
            return;
        end
        case (op)
            5:  step({name, " DEC"}, 1'b1, d, z, n, 1'b1, MAcci | St2);
            6:  step({name, " DEC"}, 1'b1, d, z, n, 1'b1, MAccc | St2);
            7:  step({name, " DEC"}, 1'b1, d, z, n, 1'b1, MPcl | St2);
            8:  step({name, " DEC"}, 1'b1, d, z, n, 1'b1, (n ? MPcl : 18'd0) | St2);
            9:  step({name, " DEC"}, 1'b1, d, z, n, 1'b1, (z ? MPcl : 18'd0) | St2);
            10: step({name, " DEC"}, 1'b1, d, z, n, 1'b1, St2);
            default: begin
                step({name, " DEC"}, 1'b1, d, z, n, 1'b1, MMarl | MMars | St2);
                we  = (op == 1) ? MWe : 18'd0;
                alu = (op == 0) ? 2'b00 : (op == 2) ? 2'b01 : (op == 3) ? 2'b10 : 2'b11;
                for (int k = 0; k <= WaitMax; k++) begin
                    if (k == mem_delay) begin
                        e = MReq | we | St3;
                        if (op != 1) e = e | MAccl | {8'b0, alu, 8'b0};
                        step({name, " MEM ack"}, 1'b1, noise, z, n, 1'b1, e);
                        break;
                    end else if (k == WaitMax) begin
                        step({name, " MEM timeout"}, 1'b1, noise, z, n, 1'b0,
                             MReq | we | MBerr | St3);
                        return;
                    end else begin
                        step({name, " MEM wait"}, 1'b1, noise, z, n, 1'b0, MReq | we | St3);
                    end
                end
            end
        endcase
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n   = 1'b0;
        D       = '0;
        z_flag  = 1'b0;
        n_flag  = 1'b0;
        mem_ack = 1'b0;

        do_reset();
        do_instr("INC", oh(5), 1'b0, 1'b0, 0, 0);
        do_instr("CLR", oh(6), 1'b0, 1'b0, 0, 0);
        do_instr("JMP", oh(7), 1'b0, 1'b0, 0, 0);
        do_instr("JPZ z0", oh(9), 1'b0, 1'b1, 0, 0);
        do_instr("JPZ z1", oh(9), 1'b1, 1'b0, 0, 0);
        do_instr("JPN n0", oh(8), 1'b1, 1'b0, 0, 0);
        do_instr("JPN n1", oh(8), 1'b0, 1'b1, 0, 0);
        do_instr("LDA", oh(0), 1'b0, 1'b0, 0, 0);
        do_instr("ADD", oh(2), 1'b0, 1'b0, 1, 2);
        do_instr("SUB", oh(3), 1'b0, 1'b0, 0, 1);
        do_instr("XOR", oh(4), 1'b0, 1'b0, 0, 0);
        do_instr("STA", oh(1), 1'b0, 1'b0, 0, 2);
        do_instr("ILL zero", 16'h0, 1'b0, 1'b0, 0, 0);
        do_instr("ILL multi", oh(2) | oh(3), 1'b0, 1'b0, 0, 0);
        do_instr("ILL unused", oh(12), 1'b0, 1'b0, 0, 0);
        do_instr("INC slow", oh(5), 1'b0, 1'b0, 3, 0);
        do_instr("HLT", oh(10), 1'b0, 1'b0, 0, 0);
        halt_cycles(20);

        do_reset();
        do_instr("F1 timeout", oh(5), 1'b0, 1'b0, 100, 0);
        halt_cycles(3);

        do_reset();
        do_instr("LDA late", oh(0), 1'b0, 1'b0, 15, 15);
        do_instr("INC after", oh(5), 1'b0, 1'b0, 0, 0);

        do_reset();
        do_instr("MEM timeout", oh(2), 1'b0, 1'b0, 0, 100);
        halt_cycles(3);

        // Reset arriving mid-request must kill mem_req and any completion strobe.
        do_reset();
        step("midreq F0", 1'b1, oh(5), 1'b0, 1'b0, 1'b0, MMarl | St0);
        step("midreq rst", 1'b0, oh(5), 1'b0, 1'b0, 1'b1, 18'd0);
        do_reset();
        do_instr("JMP final", oh(7), 1'b0, 1'b0, 0, 0);

        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
